// File: rtl/pim_act_pingpong_buffer.sv
// Double-buffered activation buffer: assembles loader words into vectors
// in one bank while the PIM macro consumes the completed vector in the other.
module pim_act_pingpong_buffer #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_WORDS = 9,
  parameter int unsigned CNT_W     = $clog2(NUM_WORDS + 1)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_clear,
  input  logic                        i_wr_valid,
  input  logic [DATA_W-1:0]           i_wr_data,
  input  logic                        i_wr_last,
  output logic                        o_wr_ready,
  output logic                        o_act_valid,
  output logic [DATA_W*NUM_WORDS-1:0] o_act_data,
  input  logic                        i_act_ready,
  output logic [CNT_W-1:0]            o_fill_count,
  output logic [1:0]                  o_full_banks
);

  localparam int unsigned VEC_W = DATA_W * NUM_WORDS;

  logic [VEC_W-1:0] bank [2];
  logic [1:0]       full;
  logic             wr_sel;
  logic             rd_sel;
  logic [CNT_W-1:0] wr_idx;

  logic wr_fire;
  logic wr_done;
  logic rd_fire;

  // Handshake decode; depends only on registered state plus the request inputs
  always_comb begin
    wr_fire = i_wr_valid & ~full[wr_sel];
    wr_done = wr_fire & ((wr_idx == CNT_W'(NUM_WORDS - 1)) | i_wr_last);
    rd_fire = full[rd_sel] & i_act_ready;
  end

  // Output view of the registered state
  always_comb begin
    o_wr_ready   = ~full[wr_sel];
    o_act_valid  = full[rd_sel];
    o_act_data   = full[rd_sel] ? bank[rd_sel] : '0;
    o_fill_count = wr_idx;
    o_full_banks = 2'({1'b0, full[0]} + {1'b0, full[1]});
  end

  // Bank storage: released banks are zeroed so short vectors read zero-padded
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      bank[0] <= '0;
      bank[1] <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (rd_fire && (rd_sel == 1'(b))) begin
          bank[b] <= '0;
        end else if (wr_fire && (wr_sel == 1'(b))) begin
          for (int k = 0; k < NUM_WORDS; k++) begin
            if (wr_idx == CNT_W'(k)) begin
              bank[b][DATA_W*(NUM_WORDS-1-k) +: DATA_W] <= i_wr_data;
            end
          end
        end
      end
    end
  end

  // Full flags and bank pointers; a completing write and a release of the
  // other bank in the same cycle both take effect
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      full   <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      wr_idx <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (rd_fire && (rd_sel == 1'(b))) begin
          full[b] <= 1'b0;
        end else if (wr_done && (wr_sel == 1'(b))) begin
          full[b] <= 1'b1;
        end
      end
      if (rd_fire) begin
        rd_sel <= ~rd_sel;
      end
      if (wr_done) begin
        wr_sel <= ~wr_sel;
        wr_idx <= '0;
      end else if (wr_fire) begin
        wr_idx <= wr_idx + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pim_act_pingpong_buffer.sv
// Directed self-checking bench for pim_act_pingpong_buffer (DATA_W=32, NUM_WORDS=9).
module tb_pim_act_pingpong_buffer;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned NUM_WORDS = 9;
  localparam int unsigned CNT_W     = $clog2(NUM_WORDS + 1);
  localparam int unsigned VEC_W     = DATA_W * NUM_WORDS;

  logic                clk = 1'b0;
  logic                rst;
  logic                clear;
  logic                wr_valid;
  logic [DATA_W-1:0]   wr_data;
  logic                wr_last;
  logic                wr_ready;
  logic                act_valid;
  logic [VEC_W-1:0]    act_data;
  logic                act_ready;
  logic [CNT_W-1:0]    fill_count;
  logic [1:0]          full_banks;

  int tests = 0;
  int fails = 0;

  pim_act_pingpong_buffer #(.DATA_W(DATA_W), .NUM_WORDS(NUM_WORDS)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_clear      (clear),
    .i_wr_valid   (wr_valid),
    .i_wr_data    (wr_data),
    .i_wr_last    (wr_last),
    .o_wr_ready   (wr_ready),
    .o_act_valid  (act_valid),
    .o_act_data   (act_data),
    .i_act_ready  (act_ready),
    .o_fill_count (fill_count),
    .o_full_banks (full_banks)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [VEC_W-1:0] obs, input logic [VEC_W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected vector of n consecutive words starting at base, word 0 in the MSB slice
  function automatic logic [VEC_W-1:0] mkvec(input logic [DATA_W-1:0] base, input int n);
    logic [VEC_W-1:0] v;
    v = '0;
    for (int k = 0; k < n; k++) v[DATA_W*(NUM_WORDS-1-k) +: DATA_W] = base + DATA_W'(k);
    return v;
  endfunction

  task automatic write_word(input logic [DATA_W-1:0] d, input logic last);
    wr_valid = 1'b1;
    wr_data  = d;
    wr_last  = last;
    tick();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic write_seq(input logic [DATA_W-1:0] base, input int n);
    for (int k = 0; k < n; k++) write_word(base + DATA_W'(k), 1'b0);
  endtask

  task automatic release_one();
    act_ready = 1'b1;
    tick();
    act_ready = 1'b0;
  endtask

  logic [VEC_W-1:0] exp_v;
  int               vec_seen;

  initial begin
    rst = 1'b1; clear = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0; act_ready = 1'b0;
    tick(); tick();
    check("rst_wr_ready",   VEC_W'(wr_ready),   VEC_W'(1));
    check("rst_act_valid",  VEC_W'(act_valid),  VEC_W'(0));
    check("rst_act_data",   act_data,           '0);
    check("rst_fill",       VEC_W'(fill_count), VEC_W'(0));
    check("rst_full_banks", VEC_W'(full_banks), VEC_W'(0));
    rst = 1'b0;

    // Fill one vector with 1..9
    write_seq(32'h1, 8);
    check("fill8_count",   VEC_W'(fill_count), VEC_W'(8));
    check("fill8_novalid", VEC_W'(act_valid),  VEC_W'(0));
    write_word(32'h9, 1'b0);
    check("fill_valid",  VEC_W'(act_valid),  VEC_W'(1));
    check("fill_msb",    VEC_W'(act_data[287:256]), VEC_W'(32'h1));
    check("fill_lsb",    VEC_W'(act_data[31:0]),    VEC_W'(32'h9));
    check("fill_vec",    act_data, mkvec(32'h1, 9));
    check("fill_count0", VEC_W'(fill_count), VEC_W'(0));
    check("fill_banks1", VEC_W'(full_banks), VEC_W'(1));

    // Second vector fills the other bank, then the buffer stalls
    write_seq(32'ha, 9);
    check("pp_banks2",   VEC_W'(full_banks), VEC_W'(2));
    check("pp_not_rdy",  VEC_W'(wr_ready),   VEC_W'(0));
    write_word(32'hdead, 1'b0);
    check("pp_stall_fill",  VEC_W'(fill_count), VEC_W'(0));
    check("pp_stall_banks", VEC_W'(full_banks), VEC_W'(2));
    check("pp_hold_data",   act_data, mkvec(32'h1, 9));
    release_one();
    check("pp_rel_valid", VEC_W'(act_valid),  VEC_W'(1));
    check("pp_rel_data",  act_data, mkvec(32'ha, 9));
    check("pp_rel_rdy",   VEC_W'(wr_ready),   VEC_W'(1));
    check("pp_rel_banks", VEC_W'(full_banks), VEC_W'(1));
    release_one();
    check("pp_empty_valid", VEC_W'(act_valid), VEC_W'(0));
    check("pp_empty_data",  act_data, '0);

    // Short vectors, zero padding, no stale data from a prior full vector
    write_word(32'haaaa0000, 1'b0);
    write_word(32'hbbbb0000, 1'b1);
    exp_v = '0;
    exp_v[287:224] = 64'haaaa0000_bbbb0000;
    check("short_data", act_data, exp_v);
    check("short_fill", VEC_W'(fill_count), VEC_W'(0));
    release_one();
    for (int k = 0; k < 9; k++) write_word(32'hffffffff, 1'b0);
    check("ones_vec", act_data, {9{32'hffffffff}});
    release_one();
    write_word(32'hcafebabe, 1'b1);
    exp_v = '0;
    exp_v[287:256] = 32'hcafebabe;
    check("one_word_vec", act_data, exp_v);
    release_one();
    write_word(32'h11111111, 1'b0);
    write_word(32'h22222222, 1'b1);
    exp_v = '0;
    exp_v[287:224] = 64'h11111111_22222222;
    check("short_after_ones", act_data, exp_v);
    release_one();
    check("short_drained", VEC_W'(full_banks), VEC_W'(0));

    // Streaming: 90 words back-to-back with the consumer always ready
    act_ready = 1'b1;
    vec_seen  = 0;
    for (int i = 0; i < 90; i++) begin
      check("stream_ready", VEC_W'(wr_ready), VEC_W'(1));
      if (act_valid) begin
        check("stream_vec", act_data, mkvec(32'h100 + DATA_W'(9 * vec_seen), 9));
        vec_seen++;
      end
      wr_valid = 1'b1;
      wr_data  = 32'h100 + DATA_W'(i);
      tick();
    end
    wr_valid = 1'b0;
    for (int c = 0; c < 4 && vec_seen < 10; c++) begin
      if (act_valid) begin
        check("stream_vec", act_data, mkvec(32'h100 + DATA_W'(9 * vec_seen), 9));
        vec_seen++;
      end
      tick();
    end
    check("stream_count", VEC_W'(vec_seen),   VEC_W'(10));
    check("stream_empty", VEC_W'(full_banks), VEC_W'(0));
    act_ready = 1'b0;

    // Clear mid-fill with a vector pending
    write_seq(32'h300, 9);
    write_seq(32'h400, 5);
    check("clr_pre_fill",  VEC_W'(fill_count), VEC_W'(5));
    check("clr_pre_banks", VEC_W'(full_banks), VEC_W'(1));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_valid", VEC_W'(act_valid),  VEC_W'(0));
    check("clr_banks", VEC_W'(full_banks), VEC_W'(0));
    check("clr_fill",  VEC_W'(fill_count), VEC_W'(0));
    check("clr_data",  act_data, '0);
    check("clr_rdy",   VEC_W'(wr_ready),   VEC_W'(1));
    write_seq(32'h500, 9);
    check("clr_next_vec",   act_data, mkvec(32'h500, 9));
    check("clr_next_banks", VEC_W'(full_banks), VEC_W'(1));

    // Reset mid-fill takes priority over clear
    write_seq(32'h550, 3);
    rst = 1'b1; clear = 1'b1;
    tick();
    rst = 1'b0; clear = 1'b0;
    check("rst_mid_fill",  VEC_W'(fill_count), VEC_W'(0));
    check("rst_mid_valid", VEC_W'(act_valid),  VEC_W'(0));
    check("rst_mid_banks", VEC_W'(full_banks), VEC_W'(0));

    // Last word of B1 completes in the same cycle B0 is released
    write_seq(32'h600, 9);
    write_seq(32'h700, 8);
    act_ready = 1'b1;
    write_word(32'h708, 1'b0);
    act_ready = 1'b0;
    check("sim_valid", VEC_W'(act_valid),  VEC_W'(1));
    check("sim_data",  act_data, mkvec(32'h700, 9));
    check("sim_banks", VEC_W'(full_banks), VEC_W'(1));
    check("sim_rdy",   VEC_W'(wr_ready),   VEC_W'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
